pipelined_adder: RTL and testbench

Parametrised, fully pipelined two's-complement adder/subtractor that replaces the fixed 4-bit combinational adder wherever operands are wider or timing is tight. The WIDTH-bit carry chain is split into STAGES equal chunks, with one chunk resolved per pipeline stage. It accepts one operation per cycle under a valid/enable handshake and returns a (WIDTH+1)-bit result plus a signed-overflow flag after a fixed latency.

---
 rtl/pipelined_adder.sv | 132 +++++++++++++
 tb/tb_pipelined_adder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: two's-complement adder/subtractor whose WIDTH-bit carry
// chain is cut into STAGES equal chunks, one chunk resolved per stage.
// One operation per enabled cycle, fixed latency of STAGES enabled edges,
// and every output comes straight from a register.
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH:0]   sum,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;

   // Element k is the state left behind by stage k:
   //   a_q/b_q : operand chunks not yet consumed (consumed chunks cleared)
   //   r_q     : result chunks produced so far
   //   c_q     : carry out of chunk k
   //   v_q     : valid bit travelling with the operation
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] r_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];
   logic             ovf_q;

   // Illegal geometry is caught at elaboration rather than producing a
   // silently truncated carry chain.
   if ((WIDTH < 1) || (STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
      $error("pipelined_adder: STAGES must be in 1..WIDTH and divide WIDTH");
   end

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         localparam int LO = gi * CHUNK;
         // Bits above the chunk handled here; everything at or below it is
         // consumed once this stage has fired.
         localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} << ((gi + 1) * CHUNK);

         logic [WIDTH-1:0] a_in;
         logic [WIDTH-1:0] b_in;
         logic [WIDTH-1:0] r_in;
         logic             c_in;
         logic             v_in;

         logic [CHUNK:0]   part_d;
         logic [WIDTH-1:0] a_d;
         logic [WIDTH-1:0] b_d;
         logic [WIDTH-1:0] r_d;
         logic             c_d;

         if (gi == 0) begin : g_first
            // Subtraction is a + ~b + 1: invert b once here and feed the +1
            // in as the carry into the lowest chunk.
            assign a_in = a;
            assign b_in = b ^ {WIDTH{sub}};
            assign r_in = '0;
            assign c_in = sub;
            assign v_in = in_valid;
         end else begin : g_next
            assign a_in = a_q[gi-1];
            assign b_in = b_q[gi-1];
            assign r_in = r_q[gi-1];
            assign c_in = c_q[gi-1];
            assign v_in = v_q[gi-1];
         end

         // Resolve this stage's chunk using the carry handed up from below.
         always_comb begin
            part_d           = {1'b0, a_in[LO +: CHUNK]}
                             + {1'b0, b_in[LO +: CHUNK]}
                             + {{CHUNK{1'b0}}, c_in};
            c_d              = part_d[CHUNK];
            r_d              = r_in;
            r_d[LO +: CHUNK] = part_d[CHUNK-1:0];
            a_d              = a_in & KEEP;
            b_d              = b_in & KEEP;
         end

         // Advance the stage on enabled edges; reset clears data and valid.
         always_ff @(posedge clk) begin
            if (rst) begin
               a_q[gi] <= '0;
               b_q[gi] <= '0;
               r_q[gi] <= '0;
               c_q[gi] <= 1'b0;
               v_q[gi] <= 1'b0;
            end else if (en) begin
               a_q[gi] <= a_d;
               b_q[gi] <= b_d;
               r_q[gi] <= r_d;
               c_q[gi] <= c_d;
               v_q[gi] <= v_in;
            end
         end

         if (gi == STAGES - 1) begin : g_last
            logic ovf_d;

            // The top chunk is still unconsumed on entry to the last stage,
            // so the operand sign bits are available here without a side
            // pipeline. Overflow: like-signed operands, differently signed
            // result.
            assign ovf_d = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                           (r_d[WIDTH-1] != a_in[WIDTH-1]);

            // Register the overflow flag alongside the final result chunk.
            always_ff @(posedge clk) begin
               if (rst) begin
                  ovf_q <= 1'b0;
               end else if (en) begin
                  ovf_q <= ovf_d;
               end
            end
         end
      end
   endgenerate

   assign out_valid = v_q[STAGES-1];
   assign sum       = {c_q[STAGES-1], r_q[STAGES-1]};
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four instances, (8,1) (16,4) (32,8) (32,32),
// share one stimulus stream. Directed tests target the (16,4) instance;
// the random regression checks all four against an arithmetic model.
module tb_pipelined_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en;
   logic        in_valid;
   logic        sub;
   logic [31:0] a_in;
   logic [31:0] b_in;

   logic        ov0, ov1, ov2, ov3;
   logic        of0, of1, of2, of3;
   logic [8:0]  s0;
   logic [16:0] s1;
   logic [32:0] s2;
   logic [32:0] s3;

   pipelined_adder #(.WIDTH(8), .STAGES(1)) u_d0 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
      .a(a_in[7:0]), .b(b_in[7:0]), .out_valid(ov0), .sum(s0), .ovf(of0));
   pipelined_adder #(.WIDTH(16), .STAGES(4)) u_d1 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
      .a(a_in[15:0]), .b(b_in[15:0]), .out_valid(ov1), .sum(s1), .ovf(of1));
   pipelined_adder #(.WIDTH(32), .STAGES(8)) u_d2 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
      .a(a_in), .b(b_in), .out_valid(ov2), .sum(s2), .ovf(of2));
   pipelined_adder #(.WIDTH(32), .STAGES(32)) u_d3 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
      .a(a_in), .b(b_in), .out_valid(ov3), .sum(s3), .ovf(of3));

   logic        act_v [4];
   logic [32:0] act_s [4];
   logic        act_o [4];

   assign act_v[0] = ov0;  assign act_s[0] = {24'd0, s0};  assign act_o[0] = of0;
   assign act_v[1] = ov1;  assign act_s[1] = {16'd0, s1};  assign act_o[1] = of1;
   assign act_v[2] = ov2;  assign act_s[2] = s2;           assign act_o[2] = of2;
   assign act_v[3] = ov3;  assign act_s[3] = s3;           assign act_o[3] = of3;

   int w_of [4] = '{8, 16, 32, 32};
   int s_of [4] = '{1, 4, 8, 32};

   // Reference: results delayed by STAGES enabled edges.
   bit     mv [4][32];
   longint ms [4][32];
   bit     mo [4][32];

   int n_tests = 0;
   int n_fail  = 0;

   // Plain arithmetic reference: unsigned (WIDTH+1)-bit result and signed overflow.
   function automatic void calc(input int w, input logic [31:0] av_i, input logic [31:0] bv_i,
                                input logic sb, output longint s, output logic o);
      longint m, av, bv, half, sa, sbv, t;
      m    = (longint'(1) << w) - 1;
      av   = longint'(av_i) & m;
      bv   = longint'(bv_i) & m;
      if (sb) s = av + ((~bv) & m) + 1;
      else    s = av + bv;
      half = longint'(1) << (w - 1);
      sa   = (av >= half) ? av - (m + 1) : av;
      sbv  = (bv >= half) ? bv - (m + 1) : bv;
      t    = sb ? (sa - sbv) : (sa + sbv);
      o    = (t >= half) || (t < -half);
   endfunction

   task automatic model_edge();
      longint s;
      logic   o;
      for (int d = 0; d < 4; d++) begin
         if (rst) begin
            for (int k = 0; k < 32; k++) begin
               mv[d][k] = 1'b0; ms[d][k] = 0; mo[d][k] = 1'b0;
            end
         end else if (en) begin
            for (int k = 31; k > 0; k--) begin
               mv[d][k] = mv[d][k-1]; ms[d][k] = ms[d][k-1]; mo[d][k] = mo[d][k-1];
            end
            calc(w_of[d], a_in, b_in, sub, s, o);
            mv[d][0] = in_valid; ms[d][0] = s; mo[d][0] = o;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
      for (int c = 0; c < 2; c++) begin
         cycle();
         en = 1'b1;
         for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (act_v[d] !== 1'b0 || act_s[d] !== 33'd0 || act_o[d] !== 1'b0) begin
               n_fail++;
               $display("FAIL reset dut%0d cyc%0d: got v=%b s=%h o=%b required v=0 s=0 o=0",
                        d, c, act_v[d], act_s[d], act_o[d]);
            end
         end
      end
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         cycle();
         for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (act_v[d] !== 1'b0 || act_s[d] !== 33'd0 || act_o[d] !== 1'b0) begin
               n_fail++;
               $display("FAIL idle dut%0d cyc%0d: got v=%b s=%h o=%b required v=0 s=0 o=0",
                        d, c, act_v[d], act_s[d], act_o[d]);
            end
         end
      end
      $display("[TB] reset/idle done");
   endtask

   task automatic test_add_corners();
      logic [15:0] ta [3] = '{16'hFFFF, 16'h7FFF, 16'h8000};
      logic [15:0] tb [3] = '{16'h0001, 16'h0001, 16'h8000};
      logic [16:0] ts [3] = '{17'h10000, 17'h08000, 17'h10000};
      logic        to [3] = '{1'b0, 1'b1, 1'b1};
      for (int c = 0; c < 8; c++) begin
         en = 1'b1; sub = 1'b0;
         if (c < 3) begin
            in_valid = 1'b1; a_in = {16'd0, ta[c]}; b_in = {16'd0, tb[c]};
         end else begin
            in_valid = 1'b0; a_in = '0; b_in = '0;
         end
         cycle();
         if (c >= 3 && c < 6) begin
            n_tests++;
            if (act_v[1] !== 1'b1 || act_s[1][16:0] !== ts[c-3] || act_o[1] !== to[c-3]) begin
               n_fail++;
               $display("FAIL add_corner op%0d: got v=%b s=%h o=%b required v=1 s=%h o=%b",
                        c - 3, act_v[1], act_s[1][16:0], act_o[1], ts[c-3], to[c-3]);
            end
            $display("[TB] add %h+%h -> %h ovf=%b", ta[c-3], tb[c-3], act_s[1][16:0], act_o[1]);
         end else begin
            n_tests++;
            if (act_v[1] !== 1'b0) begin
               n_fail++;
               $display("FAIL add_gap cyc%0d: got out_valid=%b required 0", c, act_v[1]);
            end
         end
      end
   endtask

   task automatic test_sub_corners();
      logic [15:0] ta [3] = '{16'h0005, 16'h8000, 16'h1234};
      logic [15:0] tb [3] = '{16'h0007, 16'h0001, 16'h1234};
      logic [16:0] ts [3] = '{17'h0FFFE, 17'h17FFF, 17'h10000};
      logic        to [3] = '{1'b0, 1'b1, 1'b0};
      for (int c = 0; c < 8; c++) begin
         en = 1'b1; sub = 1'b1;
         if (c < 3) begin
            in_valid = 1'b1; a_in = {16'd0, ta[c]}; b_in = {16'd0, tb[c]};
         end else begin
            in_valid = 1'b0; a_in = '0; b_in = '0;
         end
         cycle();
         if (c >= 3 && c < 6) begin
            n_tests++;
            if (act_v[1] !== 1'b1 || act_s[1][16:0] !== ts[c-3] || act_o[1] !== to[c-3]) begin
               n_fail++;
               $display("FAIL sub_corner op%0d: got v=%b s=%h o=%b required v=1 s=%h o=%b",
                        c - 3, act_v[1], act_s[1][16:0], act_o[1], ts[c-3], to[c-3]);
            end
            $display("[TB] sub %h-%h -> %h ovf=%b", ta[c-3], tb[c-3], act_s[1][16:0], act_o[1]);
         end else begin
            n_tests++;
            if (act_v[1] !== 1'b0) begin
               n_fail++;
               $display("FAIL sub_gap cyc%0d: got out_valid=%b required 0", c, act_v[1]);
            end
         end
      end
      sub = 1'b0;
   endtask

   task automatic test_stall();
      logic [15:0] oa [3];
      logic [15:0] ob [3];
      logic        os [3];
      logic [16:0] es [3];
      logic        eo [3];
      longint      s;
      logic        o;
      int          seen = 0;
      for (int i = 0; i < 3; i++) begin
         oa[i] = 16'($urandom); ob[i] = 16'($urandom); os[i] = 1'($urandom_range(0, 1));
         calc(16, {16'd0, oa[i]}, {16'd0, ob[i]}, os[i], s, o);
         es[i] = 17'(s); eo[i] = o;
      end
      for (int c = 0; c < 13; c++) begin
         if (c < 3) begin
            en = 1'b1; in_valid = 1'b1; a_in = {16'd0, oa[c]}; b_in = {16'd0, ob[c]}; sub = os[c];
         end else if (c == 3) begin
            en = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; sub = 1'b0;
         end else if (c < 7) begin
            en = 1'b0; in_valid = 1'b1; a_in = $urandom; b_in = $urandom; sub = 1'($urandom_range(0, 1));
         end else begin
            en = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; sub = 1'b0;
         end
         cycle();
         // op0 sits at the output from cycle 3 and must stay frozen through the stall
         if (c >= 3 && c <= 6) begin
            n_tests++;
            if (act_v[1] !== 1'b1 || act_s[1][16:0] !== es[0] || act_o[1] !== eo[0]) begin
               n_fail++;
               $display("FAIL stall_frozen cyc%0d: got v=%b s=%h o=%b required v=1 s=%h o=%b",
                        c, act_v[1], act_s[1][16:0], act_o[1], es[0], eo[0]);
            end
         end
         // op2 captured at cycle 2 needs 4 enabled edges plus 3 stalled ones
         if (c == 8) begin
            n_tests++;
            if (act_v[1] !== 1'b1 || act_s[1][16:0] !== es[2] || act_o[1] !== eo[2]) begin
               n_fail++;
               $display("FAIL stall_latency: got v=%b s=%h o=%b required v=1 s=%h o=%b",
                        act_v[1], act_s[1][16:0], act_o[1], es[2], eo[2]);
            end
         end
         if (en && act_v[1]) begin
            n_tests++;
            if (seen >= 3 || act_s[1][16:0] !== es[seen] || act_o[1] !== eo[seen]) begin
               n_fail++;
               $display("FAIL stall_order result%0d: got s=%h o=%b required s=%h o=%b",
                        seen, act_s[1][16:0], act_o[1], es[seen % 3], eo[seen % 3]);
            end else begin
               $display("[TB] stall result%0d %h ovf=%b", seen, act_s[1][16:0], act_o[1]);
            end
            seen++;
         end
      end
      n_tests++;
      if (seen != 3) begin
         n_fail++;
         $display("FAIL stall_count: got %0d results required 3", seen);
      end
   endtask

   task automatic test_reset_midflight();
      for (int c = 0; c < 16; c++) begin
         en = 1'b1; sub = 1'b0;
         if (c < 4) begin
            rst = (c >= 2); in_valid = 1'b1; a_in = $urandom; b_in = $urandom;
         end else if (c == 10) begin
            rst = 1'b0; in_valid = 1'b1; a_in = 32'd3; b_in = 32'd4;
         end else begin
            rst = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
         end
         cycle();
         if (c >= 2 && c < 10) begin
            for (int d = 0; d < 4; d++) begin
               n_tests++;
               if (act_v[d] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL flush dut%0d cyc%0d: got out_valid=%b required 0", d, c, act_v[d]);
               end
            end
         end else if (c == 13) begin
            n_tests++;
            if (act_v[1] !== 1'b1 || act_s[1][16:0] !== 17'h00007 || act_o[1] !== 1'b0) begin
               n_fail++;
               $display("FAIL post_reset_op: got v=%b s=%h o=%b required v=1 s=00007 o=0",
                        act_v[1], act_s[1][16:0], act_o[1]);
            end
            $display("[TB] post-reset 0003+0004 -> %h", act_s[1][16:0]);
         end else if (c > 10) begin
            n_tests++;
            if (act_v[1] !== 1'b0) begin
               n_fail++;
               $display("FAIL post_reset_gap cyc%0d: got out_valid=%b required 0", c, act_v[1]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] corner [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_8080, 32'h7FFF_7F7F};
      int k;
      rst = 1'b1; en = 1'b1; in_valid = 1'b0;
      cycle();
      rst = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         rst      = ($urandom_range(0, 999) == 0);
         en       = ($urandom_range(0, 3) != 0);
         in_valid = 1'($urandom_range(0, 1));
         sub      = 1'($urandom_range(0, 1));
         a_in     = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         b_in     = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         cycle();
         for (int d = 0; d < 4; d++) begin
            k = s_of[d] - 1;
            n_tests++;
            if (act_v[d] !== mv[d][k]) begin
               n_fail++;
               $display("FAIL rand_valid dut%0d cyc%0d: got %b required %b", d, c, act_v[d], mv[d][k]);
            end else if (mv[d][k] && (act_s[d] !== 33'(ms[d][k]) || act_o[d] !== mo[d][k])) begin
               n_fail++;
               $display("FAIL rand_data dut%0d cyc%0d: got s=%h o=%b required s=%h o=%b",
                        d, c, act_s[d], act_o[d], 33'(ms[d][k]), mo[d][k]);
            end
         end
      end
      $display("[TB] random regression done");
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
      test_reset();
      test_add_corners();
      test_sub_corners();
      test_stall();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
